// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer feeding the HI/LO accumulator: single-cycle multiply,
// 32-step restoring divide, one-cycle write strobe and issue/read stall.
module muldiv_sequencer (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Start,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        AccRead,
  input  logic        Flush,
  output logic [63:0] Result,
  output logic        ACCEn,
  output logic        Busy,
  output logic        Stall,
  output logic        DivZero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [5:0]  r_count;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic        r_quoNeg;
  logic        r_remNeg;
  logic [63:0] r_result;
  logic        r_accEn;
  logic        r_divZero;

  logic        w_funcValid;
  logic        w_isDiv;
  logic        w_signed;
  logic        w_divByZero;
  logic        w_accept;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [32:0] w_shift;
  logic [31:0] w_sub;
  logic        w_fits;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;

  // Func 0x18..0x1B: bit1 selects divide, bit0 selects unsigned
  assign w_funcValid = (Func[5:2] == 4'b0110);
  assign w_isDiv     = Func[1];
  assign w_signed    = ~Func[0];
  assign w_divByZero = w_isDiv && (B == 32'd0);

  assign Busy     = (r_state != S_IDLE) | r_accEn;
  assign Stall    = (Start | AccRead) & Busy;
  assign w_accept = Start & w_funcValid & ~Busy & ~Flush;

  assign Result  = r_result;
  assign ACCEn   = r_accEn;
  assign DivZero = r_divZero;

  // Low 64 bits of a 64x64 product of sign-extended operands is the signed product
  assign w_prodS = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prodU = {32'd0, A} * {32'd0, B};

  assign w_absA = (w_signed && A[31]) ? (~A + 32'd1) : A;
  assign w_absB = (w_signed && B[31]) ? (~B + 32'd1) : B;

  // Remainder is below the divisor, so the true difference always fits in 32 bits
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fits  = (w_shift >= {1'b0, r_divisor});
  assign w_sub   = w_shift[31:0] - r_divisor;

  assign w_quoFinal = r_quoNeg ? (~r_quo + 32'd1) : r_quo;
  assign w_remFinal = r_remNeg ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (Flush) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept && w_isDiv && !w_divByZero) w_nextState = S_DIV;
        S_DIV:   if (r_count == 6'd1) w_nextState = S_FIX;
        S_FIX:   w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_count   <= 6'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_quoNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_result  <= 64'd0;
      r_accEn   <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_accEn <= 1'b0;
      if (Flush) begin
        r_count <= 6'd0;
      end else if (w_accept) begin
        r_divZero <= w_divByZero;
        if (!w_isDiv) begin
          r_result <= w_signed ? w_prodS : w_prodU;
          r_accEn  <= 1'b1;
        end else if (w_divByZero) begin
          r_result <= {A, 32'hFFFF_FFFF};
          r_accEn  <= 1'b1;
        end else begin
          r_rem     <= 32'd0;
          r_quo     <= w_absA;
          r_divisor <= w_absB;
          r_count   <= 6'd32;
          r_quoNeg  <= w_signed & (A[31] ^ B[31]);
          r_remNeg  <= w_signed & A[31];
        end
      end else if (r_state == S_DIV) begin
        r_rem   <= w_fits ? w_sub : w_shift[31:0];
        r_quo   <= {r_quo[30:0], w_fits};
        r_count <= r_count - 6'd1;
      end else if (r_state == S_FIX) begin
        r_result <= {w_remFinal, w_quoFinal};
        r_accEn  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: multiply, divide, divide-by-zero,
// flush, asynchronous reset mid-divide and stall behaviour around the write strobe.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic [5:0]  Func;
  logic [31:0] A;
  logic [31:0] B;
  logic        AccRead;
  logic        Flush;
  logic [63:0] Result;
  logic        ACCEn;
  logic        Busy;
  logic        Stall;
  logic        DivZero;

  int checks = 0;
  int errors = 0;
  int ticks;
  int pulses;

  muldiv_sequencer dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Start   (Start),
    .Func    (Func),
    .A       (A),
    .B       (B),
    .AccRead (AccRead),
    .Flush   (Flush),
    .Result  (Result),
    .ACCEn   (ACCEn),
    .Busy    (Busy),
    .Stall   (Stall),
    .DivZero (DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic start, input logic [5:0] func,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic accRead, input logic flush);
    Start   = start;
    Func    = func;
    A       = a;
    B       = b;
    AccRead = accRead;
    Flush   = flush;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge and settle, away from the next edge
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  // Ticks until ACCEn rises, bounded so a dead DUT still reaches the summary
  task automatic waitAccEn(input int maxTicks, output int n);
    n = 0;
    while (ACCEn !== 1'b1 && n < maxTicks) begin
      tick();
      n++;
    end
  endtask

  initial begin
    nReset = 1'b0;
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    #12;
    checkOutput("reset Result",  Result,  64'd0);
    checkOutput("reset ACCEn",   ACCEn,   1'b0);
    checkOutput("reset Busy",    Busy,    1'b0);
    checkOutput("reset Stall",   Stall,   1'b0);
    checkOutput("reset DivZero", DivZero, 1'b0);
    nReset = 1'b1;
    tick();

    // Unrecognised Func is ignored
    applyStimulus(1'b1, 6'h20, 32'd3, 32'd4, 1'b0, 1'b0);
    tick();
    checkOutput("bad func ACCEn", ACCEn, 1'b0);

    // MULT then a back-to-back MULTU held through the write cycle
    applyStimulus(1'b1, F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    tick();
    checkOutput("mult ACCEn",  ACCEn,  1'b1);
    checkOutput("mult Result", Result, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("mult Busy",   Busy,   1'b1);
    applyStimulus(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    #1;
    checkOutput("b2b Stall", Stall, 1'b1);
    tick();
    checkOutput("b2b held ACCEn",  ACCEn,  1'b0);
    checkOutput("b2b held Result", Result, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("b2b Stall free",  Stall,  1'b0);
    tick();
    checkOutput("multu ACCEn",  ACCEn,  1'b1);
    checkOutput("multu Result", Result, 64'h0000_0001_FFFF_FFFE);
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    checkOutput("multu single pulse", ACCEn, 1'b0);

    // DIVU 100/7 with AccRead held: stalled throughout, strobe on cycle 34
    applyStimulus(1'b1, F_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("divu busy %0d", i),  Busy,  1'b1);
      checkOutput($sformatf("divu stall %0d", i), Stall, 1'b1);
      checkOutput($sformatf("divu acc %0d", i),   ACCEn, 1'b0);
      tick();
    end
    tick();
    checkOutput("divu ACCEn",  ACCEn,  1'b1);
    checkOutput("divu Result", Result, {32'h2, 32'hE});
    checkOutput("divu Stall on write", Stall, 1'b1);
    tick();
    checkOutput("divu ACCEn drop", ACCEn, 1'b0);
    checkOutput("divu Busy drop",  Busy,  1'b0);
    checkOutput("divu Stall drop", Stall, 1'b0);
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);

    // Signed divides, including the overflow case
    applyStimulus(1'b1, F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    waitAccEn(40, ticks);
    checkOutput("div -7/2 latency", ticks, 33);
    checkOutput("div -7/2 Result", Result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tick();
    applyStimulus(1'b1, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    waitAccEn(40, ticks);
    checkOutput("div ovf latency", ticks, 33);
    checkOutput("div ovf Result", Result, {32'h0, 32'h8000_0000});
    checkOutput("div ovf DivZero", DivZero, 1'b0);
    tick();

    // Divide by zero: one-cycle result, sticky flag cleared by the next accepted MULT
    applyStimulus(1'b1, F_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("div0 ACCEn",   ACCEn,   1'b1);
    checkOutput("div0 Result",  Result,  {32'h5, 32'hFFFF_FFFF});
    checkOutput("div0 DivZero", DivZero, 1'b1);
    tick();
    checkOutput("div0 Busy idle",     Busy,    1'b0);
    checkOutput("div0 DivZero stick", DivZero, 1'b1);
    applyStimulus(1'b1, F_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mult after div0 Result",  Result,  64'd12);
    checkOutput("mult after div0 DivZero", DivZero, 1'b0);
    tick();

    // Start coinciding with Flush is ignored
    applyStimulus(1'b1, F_MULT, 32'd9, 32'd9, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("flush+start ACCEn",  ACCEn,  1'b0);
    checkOutput("flush+start Result", Result, 64'd12);

    // Flush at divide step 10: no write ever, then a MULT completes normally
    applyStimulus(1'b1, F_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("flush Busy",   Busy,   1'b0);
    checkOutput("flush Result", Result, 64'd12);
    pulses = 0;
    repeat (30) begin
      if (ACCEn === 1'b1) pulses++;
      tick();
    end
    checkOutput("flush no ACCEn", pulses, 0);
    applyStimulus(1'b1, F_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("post-flush mult ACCEn",  ACCEn,  1'b1);
    checkOutput("post-flush mult Result", Result, 64'd42);
    tick();

    // Asynchronous reset at divide step 20
    applyStimulus(1'b1, F_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (19) tick();
    checkOutput("pre-reset Busy", Busy, 1'b1);
    nReset = 1'b0;
    #1;
    checkOutput("async rst Result",  Result,  64'd0);
    checkOutput("async rst ACCEn",   ACCEn,   1'b0);
    checkOutput("async rst Busy",    Busy,    1'b0);
    checkOutput("async rst Stall",   Stall,   1'b0);
    checkOutput("async rst DivZero", DivZero, 1'b0);
    tick();
    nReset = 1'b1;
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    pulses = 0;
    repeat (20) begin
      if (ACCEn === 1'b1) pulses++;
      tick();
    end
    checkOutput("post-reset no ACCEn", pulses, 0);

    // DIV with a MULTU held on Start throughout
    applyStimulus(1'b1, F_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, F_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 33; i++) begin
      if (Stall !== 1'b1) pulses++;
      tick();
    end
    checkOutput("held multu stall", pulses, 0);
    checkOutput("held div ACCEn",   ACCEn,  1'b1);
    checkOutput("held div Result",  Result, {32'd1, 32'd333});
    checkOutput("held Stall write", Stall,  1'b1);
    tick();
    checkOutput("held multu not yet", ACCEn, 1'b0);
    checkOutput("held Stall free",    Stall, 1'b0);
    tick();
    applyStimulus(1'b0, 6'h00, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("held multu ACCEn",  ACCEn,  1'b1);
    checkOutput("held multu Result", Result, 64'd30);
    pulses = 0;
    repeat (5) begin
      tick();
      if (ACCEn === 1'b1) pulses++;
    end
    checkOutput("held multu one pulse", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
